// File: rtl/reg_dump_streamer.sv
// Snapshots NUM_REGS debug registers and streams them as a framed byte stream: header, data MSB-first, XOR checksum.
// Latency: header valid 1 edge after dump_start; with tx_ready held high, one byte transfers per cycle (130-byte frame).
// Backpressure: tx_data/tx_valid hold while tx_ready is low; dump_start is ignored (not queued) while busy or during done.
module reg_dump_streamer #(
    parameter int          NUM_REGS    = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           dump_start,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
    output logic [7:0]                     tx_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic                           busy,
    output logic                           done
);

    localparam int NUM_BYTES = NUM_REGS * 4;
    localparam int CW        = $clog2(NUM_BYTES);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, HEADER, DATA, CHKSUM} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt, byte_idx;
    logic [7:0]            chk, chk_nxt, tx_data_nxt, sel_byte;
    logic                  tx_valid_nxt, busy_nxt, done_nxt, capture, xfer;
    logic [DATA_WIDTH-1:0] snap [NUM_REGS];
    logic [DATA_WIDTH-1:0] sel_word;

    assign xfer = tx_valid & tx_ready;

    // Byte to load after the current transfer: byte 0 after the header, cnt+1 inside DATA.
    always_comb begin
        byte_idx = (state == DATA) ? cnt + 1'b1 : '0;
        sel_word = snap[byte_idx[CW-1:2]];
        case (byte_idx[1:0])
            2'd0:    sel_byte = sel_word[31:24];
            2'd1:    sel_byte = sel_word[23:16];
            2'd2:    sel_byte = sel_word[15:8];
            default: sel_byte = sel_word[7:0];
        endcase
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        chk_nxt      = chk;
        tx_data_nxt  = tx_data;
        tx_valid_nxt = tx_valid;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                // The done cycle still belongs to the previous frame, so a start there is dropped.
                if (dump_start && !done) begin
                    capture      = 1'b1;
                    tx_data_nxt  = HEADER_BYTE;
                    tx_valid_nxt = 1'b1;
                    busy_nxt     = 1'b1;
                    cnt_nxt      = '0;
                    chk_nxt      = 8'h00;
                    state_nxt    = HEADER;
                end
            end
            HEADER: begin
                if (xfer) begin
                    tx_data_nxt = sel_byte;
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (xfer) begin
                    chk_nxt = chk ^ tx_data;
                    if (cnt == LAST_IDX) begin
                        tx_data_nxt = chk ^ tx_data;
                        state_nxt   = CHKSUM;
                    end else begin
                        cnt_nxt     = cnt + 1'b1;
                        tx_data_nxt = sel_byte;
                    end
                end
            end
            CHKSUM: begin
                if (xfer) begin
                    tx_valid_nxt = 1'b0;
                    busy_nxt     = 1'b0;
                    done_nxt     = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            chk      <= 8'h00;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            chk      <= chk_nxt;
            tx_data  <= tx_data_nxt;
            tx_valid <= tx_valid_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

    // Snapshot content is meaningless until a start captures it, so it carries no reset.
    always_ff @(posedge clock) begin
        if (capture) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                snap[i] <= regs_flat[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule
